hilo_unit: RTL and testbench

HILO_UNIT -- requirements
Module: hilo_unit

---
 rtl/hilo_unit_pkg.sv | 38 +++
 rtl/hilo_unit_if.sv | 24 ++
 rtl/hilo_unit_mul.sv | 19 +
 rtl/hilo_unit.sv | 163 ++++++++++++++++
 tb/tb_hilo_unit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO unit: one-hot op bit positions, FSM state
// encoding and divider op encoding. Build option: HILO_MUL_REG_EN adds the
// MUL_WAIT state used when the multiplier product is registered.
package hilo_unit_pkg;

  localparam int OP_W = 8;

  // Bit positions inside the one-hot op vector
  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;
  localparam int OP_MTHI  = 4;
  localparam int OP_MTLO  = 5;
  localparam int OP_MFHI  = 6;
  localparam int OP_MFLO  = 7;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DIV_ISSUE = 3'd1,
    S_DIV_WAIT  = 3'd2,
`ifdef HILO_MUL_REG_EN
    S_DIV_DRAIN = 3'd3,
    S_MUL_WAIT  = 3'd4
`else
    S_DIV_DRAIN = 3'd3
`endif
  } state_t;

  // Divider op: bit0 signed, bit1 unsigned
  localparam logic [1:0] DIV_OP_SIGNED   = 2'b01;
  localparam logic [1:0] DIV_OP_UNSIGNED = 2'b10;

  function automatic logic [1:0] div_op_of(input logic [OP_W-1:0] op);
    return op[OP_DIVU] ? DIV_OP_UNSIGNED : DIV_OP_SIGNED;
  endfunction

endpackage

// File: rtl/hilo_unit_if.sv
// EX-stage request/response bundle between the pipeline and the HI/LO unit.
interface hilo_unit_if;
  import hilo_unit_pkg::*;

  logic            op_valid;
  logic [OP_W-1:0] op;
  logic [31:0]     src1;
  logic [31:0]     src2;
  logic            flush;
  logic            op_ready;
  logic [31:0]     rdata;

  // Pipeline side
  modport master (
    output op_valid, op, src1, src2, flush,
    input  op_ready, rdata
  );

  // HI/LO unit side
  modport slave (
    input  op_valid, op, src1, src2, flush,
    output op_ready, rdata
  );
endinterface

// File: rtl/hilo_unit_mul.sv
// 32x32 -> 64 multiplier. mul_op[0] selects signed, mul_op[1] unsigned;
// operands are sign- or zero-extended to 33 bits so one signed multiply
// covers both flavours.
module hilo_unit_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  mul_op,
  output logic [63:0] prod
);
  logic              sgn;
  logic signed [32:0] ea, eb;
  logic signed [65:0] full;

  assign sgn  = mul_op[0] & ~mul_op[1];
  assign ea   = {sgn & a[31], a};
  assign eb   = {sgn & b[31], b};
  assign full = ea * eb;
  assign prod = full[63:0];
endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: executes mult/multu/div/divu/mthi/mtlo/mfhi/mflo for
// the EX stage. Multiplier is internal, divider external via a
// valid/ready handshake. Build option: HILO_MUL_REG_EN registers the product
// so mult takes two cycles (IDLE -> MUL_WAIT).
module hilo_unit
  import hilo_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  hilo_unit_if.slave  ex,
  output logic [1:0]  div_op,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_in_valid,
  output logic        div_out_ready,
  input  logic [63:0] div_result,
  input  logic        div_out_valid,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state, state_nx;
  logic [63:0] prod;
  logic        accept;
  logic        op_ready;
  logic        hi_we, lo_we;
  logic [31:0] hi_nx, lo_nx;
  logic        latch_div;
`ifdef HILO_MUL_REG_EN
  logic [63:0] prod_q;
  logic        mul_cap;
`endif

  hilo_unit_mul u_mul (
    .a      (ex.src1),
    .b      (ex.src2),
    .mul_op ({ex.op[OP_MULTU], ex.op[OP_MULT]}),
    .prod   (prod)
  );

  assign accept        = ex.op_valid && !ex.flush;
  assign div_in_valid  = (state == S_DIV_ISSUE);
  assign div_out_ready = (state == S_DIV_WAIT) || (state == S_DIV_DRAIN);
  assign ex.op_ready   = op_ready;
  // HI/LO are committed at the completing edge, so a read in the next cycle
  // sees the new value without any bypass.
  assign ex.rdata      = !ex.op_valid     ? 32'd0 :
                         ex.op[OP_MFHI]   ? hi    :
                         ex.op[OP_MFLO]   ? lo    : 32'd0;

  // Next-state, completion and HI/LO write selection
  always_comb begin
    state_nx  = state;
    op_ready  = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_nx     = hi;
    lo_nx     = lo;
    latch_div = 1'b0;
`ifdef HILO_MUL_REG_EN
    mul_cap   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (ex.op[OP_MULT] || ex.op[OP_MULTU]) begin
`ifdef HILO_MUL_REG_EN
            mul_cap  = 1'b1;
            state_nx = S_MUL_WAIT;
`else
            op_ready = 1'b1;
            hi_we    = 1'b1;
            lo_we    = 1'b1;
            hi_nx    = prod[63:32];
            lo_nx    = prod[31:0];
`endif
          end else if (ex.op[OP_DIV] || ex.op[OP_DIVU]) begin
            latch_div = 1'b1;
            state_nx  = S_DIV_ISSUE;
          end else if (ex.op[OP_MTHI]) begin
            op_ready = 1'b1;
            hi_we    = 1'b1;
            hi_nx    = ex.src1;
          end else if (ex.op[OP_MTLO]) begin
            op_ready = 1'b1;
            lo_we    = 1'b1;
            lo_nx    = ex.src1;
          end else if (ex.op[OP_MFHI] || ex.op[OP_MFLO]) begin
            op_ready = 1'b1;
          end
        end
      end
      // The issue pulse goes out even if flushed; the divider result is then
      // drained and dropped.
      S_DIV_ISSUE: state_nx = ex.flush ? S_DIV_DRAIN : S_DIV_WAIT;
      S_DIV_WAIT: begin
        if (ex.flush) begin
          state_nx = div_out_valid ? S_IDLE : S_DIV_DRAIN;
        end else if (div_out_valid) begin
          op_ready = 1'b1;
          hi_we    = 1'b1;
          lo_we    = 1'b1;
          hi_nx    = div_result[63:32];
          lo_nx    = div_result[31:0];
          state_nx = S_IDLE;
        end
      end
      S_DIV_DRAIN: if (div_out_valid) state_nx = S_IDLE;
`ifdef HILO_MUL_REG_EN
      S_MUL_WAIT: begin
        state_nx = S_IDLE;
        if (!ex.flush) begin
          op_ready = 1'b1;
          hi_we    = 1'b1;
          lo_we    = 1'b1;
          hi_nx    = prod_q[63:32];
          lo_nx    = prod_q[31:0];
        end
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // State register; reset abandons any division in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Architectural HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_nx;
      if (lo_we) lo <= lo_nx;
    end
  end

  // Divider operands, held stable until the unit returns to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_dividend <= '0;
      div_divisor  <= '0;
      div_op       <= '0;
    end else if (latch_div) begin
      div_dividend <= ex.src1;
      div_divisor  <= ex.src2;
      div_op       <= div_op_of(ex.op);
    end
  end

`ifdef HILO_MUL_REG_EN
  // Registered product consumed in MUL_WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          prod_q <= '0;
    else if (mul_cap) prod_q <= prod;
  end
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: the driver pushes expected HI/LO/rdata on
// each issued op, a monitor pops on every op_ready. Includes an external
// divider model with fixed latency.
module tb_hilo_unit;
  import hilo_unit_pkg::*;

  localparam int DIV_LAT = 20;
`ifdef HILO_MUL_REG_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  div_op;
  logic [31:0] div_dividend, div_divisor;
  logic        div_in_valid, div_out_ready;
  logic [63:0] div_result;
  logic        div_out_valid;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  hilo_unit_if ex_if ();

  hilo_unit dut (
    .clk           (clk),
    .rst           (rst),
    .ex            (ex_if),
    .div_op        (div_op),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_in_valid  (div_in_valid),
    .div_out_ready (div_out_ready),
    .div_result    (div_result),
    .div_out_valid (div_out_valid),
    .hi            (hi),
    .lo            (lo)
  );

  typedef struct packed {
    logic        chk;
    logic [31:0] rd;
    logic [31:0] h;
    logic [31:0] l;
  } exp_t;

  exp_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   in_pulses = 0;
  logic [31:0] cap_d, cap_s;
  logic [1:0]  cap_op;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic chk, input logic [31:0] rd, input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.chk = chk; e.rd = rd; e.h = h; e.l = l;
    sbq.push_back(e);
  endtask

  function automatic logic [7:0] onehot(input int b);
    logic [7:0] o;
    o = '0;
    o[b] = 1'b1;
    return o;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the op completed
  task automatic issue(input int opb, input logic [31:0] a, input logic [31:0] b, output int waits);
    ex_if.op = onehot(opb); ex_if.src1 = a; ex_if.src2 = b; ex_if.op_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (ex_if.op_ready) break;
      waits++;
      if (waits > 300) begin
        n_total++;
        $display("FAIL op_ready_timeout: got no op_ready expected op_ready within 300 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    ex_if.op_valid = 1'b0; ex_if.op = '0;
  endtask

  // Monitor: compare every completion with the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ex_if.op_ready) begin
        if (sbq.size() == 0) begin
          check("spurious_op_ready", {63'd0, ex_if.op_ready}, 64'd0);
        end else begin
          e = sbq.pop_front();
          if (e.chk) check("rdata", ex_if.rdata, e.rd);
          @(posedge clk); #1;
          check("hi", hi, e.h);
          check("lo", lo, e.l);
        end
      end
    end
  end

  // External divider model: fixed latency, result held until accepted
  initial begin
    logic hs, iv, busy;
    int   cnt;
    int   sa, sd;
    int unsigned ua, ud;
    div_out_valid = 1'b0; div_result = '0; busy = 1'b0; cnt = 0;
    forever begin
      @(negedge clk);
      hs = div_out_valid && div_out_ready;
      iv = div_in_valid;
      @(posedge clk); #1;
      if (rst) begin
        div_out_valid = 1'b0; busy = 1'b0;
      end else begin
        if (hs) div_out_valid = 1'b0;
        if (iv) begin
          busy = 1'b1; cnt = DIV_LAT; in_pulses++;
          cap_d = div_dividend; cap_s = div_divisor; cap_op = div_op;
        end else if (busy) begin
          cnt--;
          if (cnt == 0) begin
            busy = 1'b0;
            div_out_valid = 1'b1;
            if (cap_op[0]) begin
              sa = cap_d; sd = cap_s;
              div_result = {32'(sa % sd), 32'(sa / sd)};
            end else begin
              ua = cap_d; ud = cap_s;
              div_result = {32'(ua % ud), 32'(ua / ud)};
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    int w, p0;
    rst = 1'b1;
    ex_if.op_valid = 1'b0; ex_if.op = '0; ex_if.src1 = '0; ex_if.src2 = '0; ex_if.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_op_ready", ex_if.op_ready, 0);
    check("rst_div_in_valid", div_in_valid, 0);
    check("rst_div_out_ready", div_out_ready, 0);
    check("rst_rdata", ex_if.rdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // mult / multu followed by back-to-back reads
    push(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE);
    issue(OP_MULT, 32'hFFFFFFFF, 32'h2, w);
    check("mult_latency", w, MUL_LAT);
    push(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    issue(OP_MFHI, 0, 0, w);
    check("mfhi_latency", w, 0);
    push(0, 0, 32'h00000001, 32'hFFFFFFFE);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'h2, w);
    check("multu_latency", w, MUL_LAT);
    push(1, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE);
    issue(OP_MFLO, 0, 0, w);

    // mthi/mfhi, mtlo/mflo
    push(0, 0, 32'hA5A5A5A5, 32'hFFFFFFFE);
    issue(OP_MTHI, 32'hA5A5A5A5, 0, w);
    check("mthi_latency", w, 0);
    push(1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hFFFFFFFE);
    issue(OP_MFHI, 0, 0, w);
    push(0, 0, 32'hA5A5A5A5, 32'h5A5A5A5A);
    issue(OP_MTLO, 32'h5A5A5A5A, 0, w);
    push(1, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A);
    issue(OP_MFLO, 0, 0, w);

    // signed divide -7/2: q=-3, r=-1
    p0 = in_pulses;
    push(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(OP_DIV, 32'hFFFFFFF9, 32'h2, w);
    check("div_pulses", in_pulses - p0, 1);
    check("div_latency", w, 22);
    check("div_dividend", cap_d, 32'hFFFFFFF9);
    check("div_divisor", cap_s, 32'h2);
    check("div_op", cap_op, 2'b01);
    push(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(OP_MFHI, 0, 0, w);

    // op==0 and op_valid==0 do nothing
    ex_if.op = '0; ex_if.op_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("noop_ready", ex_if.op_ready, 0);
    end
    ex_if.op = onehot(OP_MTHI); ex_if.src1 = 32'hDEADBEEF; ex_if.op_valid = 1'b0;
    @(negedge clk);
    check("invalid_ready", ex_if.op_ready, 0);
    @(posedge clk); #1;
    check("invalid_no_write", hi, 32'hFFFFFFFF);
    ex_if.op = '0;

    // divu 7/2 flushed 5 cycles after issue; mthi stalls behind the drain
    p0 = in_pulses;
    ex_if.op = onehot(OP_DIVU); ex_if.src1 = 32'd7; ex_if.src2 = 32'd2; ex_if.op_valid = 1'b1;
    @(posedge clk); #1;
    check("issue_pulse", div_in_valid, 1);
    repeat (5) @(posedge clk);
    #1;
    ex_if.flush = 1'b1; ex_if.op_valid = 1'b0;
    @(posedge clk); #1;
    ex_if.flush = 1'b0;
    check("drain_out_ready", div_out_ready, 1);
    check("drain_hi", hi, 32'hFFFFFFFF);
    push(0, 0, 32'h00001234, 32'hFFFFFFFD);
    issue(OP_MTHI, 32'h00001234, 0, w);
    check("mthi_stalled", (w >= 10), 1);
    check("flush_div_pulses", in_pulses - p0, 1);

    // reset in DIV_WAIT
    ex_if.op = onehot(OP_DIV); ex_if.src1 = 32'd100; ex_if.src2 = 32'd3; ex_if.op_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wait_out_ready", div_out_ready, 1);
    #2;
    rst = 1'b1; ex_if.op_valid = 1'b0; ex_if.op = '0;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_div_in_valid", div_in_valid, 0);
    check("arst_div_out_ready", div_out_ready, 0);
    check("arst_op_ready", ex_if.op_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {div_in_valid, div_out_ready}, 0);
    push(0, 0, 32'h00000001, 32'hFFFFFFFE);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'h2, w);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
